// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg: 2-bit saturating counter type, states and helpers for predictors
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bp_pkg;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t SNT = 2'd0;
  localparam ctr2_t WNT = 2'd1;
  localparam ctr2_t WT  = 2'd2;
  localparam ctr2_t ST  = 2'd3;

  function automatic ctr2_t sat_inc(input ctr2_t c);
    return (c == ST) ? ST : ctr2_t'(c + 2'd1);
  endfunction

  function automatic ctr2_t sat_dec(input ctr2_t c);
    return (c == SNT) ? SNT : ctr2_t'(c - 2'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btb_array.sv
// ---------------------------------------------------------------------------
// btb_array: direct-mapped tagged BTB, two combinational reads, one sync write
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btb_array #(
  parameter int PC_W  = 5,
  parameter int IDX_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      lk_idx,
  output logic                  lk_valid,
  output logic [PC_W-IDX_W-1:0] lk_tag,
  output logic [PC_W-1:0]       lk_target,
  input  logic [IDX_W-1:0]      up_idx,
  output logic                  up_valid,
  output logic [PC_W-IDX_W-1:0] up_tag,
  output logic [PC_W-1:0]       up_target,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [PC_W-IDX_W-1:0] wr_tag,
  input  logic [PC_W-1:0]       wr_target
);

  localparam int N     = 2 ** IDX_W;
  localparam int TAG_W = PC_W - IDX_W;

  logic             r_valid  [N];
  logic [TAG_W-1:0] r_tag    [N];
  logic [PC_W-1:0]  r_target [N];

  assign lk_valid  = r_valid[lk_idx];
  assign lk_tag    = r_tag[lk_idx];
  assign lk_target = r_target[lk_idx];
  assign up_valid  = r_valid[up_idx];
  assign up_tag    = r_tag[up_idx];
  assign up_target = r_target[up_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
    end else if (wr_en) begin
      r_valid[wr_idx]  <= 1'b1;
      r_tag[wr_idx]    <= wr_tag;
      r_target[wr_idx] <= wr_target;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gshare_btb_predictor.sv
// ---------------------------------------------------------------------------
// gshare_btb_predictor: gshare PHT + tagged BTB with registered lookup and stats
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gshare_btb_predictor
  import bp_pkg::*;
#(
  parameter int PC_W   = 5,
  parameter int IDX_W  = 2,
  parameter int HIST_W = 2,
  parameter int PC_INC = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid,
  input  logic [PC_W-1:0]   pred_pc,
  output logic              pred_out_valid,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [PC_W-1:0]   upd_next_pc,
  output logic [CNT_W-1:0]  correct_cnt,
  output logic [CNT_W-1:0]  total_cnt
);

  localparam int             TAG_W = PC_W - IDX_W;
  localparam int             PHT_N = 2 ** HIST_W;
  localparam logic [PC_W-1:0] C_INC = PC_W'(PC_INC);

  ctr2_t             r_pht [PHT_N];
  logic [HIST_W-1:0] r_ghr;
  logic [HIST_W-1:0] w_ghr_next;

  logic              w_lk_valid, w_up_valid;
  logic [TAG_W-1:0]  w_lk_tag, w_up_tag;
  logic [PC_W-1:0]   w_lk_btb_tgt, w_up_btb_tgt;

  logic [HIST_W-1:0] w_lk_pidx, w_up_pidx;
  logic              w_lk_taken, w_up_taken, w_actual_taken, w_correct;
  logic [PC_W-1:0]   w_lk_target, w_up_target, w_up_fall;

  btb_array #(.PC_W(PC_W), .IDX_W(IDX_W)) u_btb (
    .clk       (clk),
    .rst       (rst),
    .lk_idx    (pred_pc[IDX_W-1:0]),
    .lk_valid  (w_lk_valid),
    .lk_tag    (w_lk_tag),
    .lk_target (w_lk_btb_tgt),
    .up_idx    (upd_pc[IDX_W-1:0]),
    .up_valid  (w_up_valid),
    .up_tag    (w_up_tag),
    .up_target (w_up_btb_tgt),
    .wr_en     (upd_valid && w_actual_taken),
    .wr_idx    (upd_pc[IDX_W-1:0]),
    .wr_tag    (upd_pc[PC_W-1:IDX_W]),
    .wr_target (upd_next_pc)
  );

  // Lookup and update both evaluate the same prediction on pre-edge state.
  assign w_lk_pidx   = pred_pc[HIST_W-1:0] ^ r_ghr;
  assign w_lk_taken  = w_lk_valid && (w_lk_tag == pred_pc[PC_W-1:IDX_W]) && r_pht[w_lk_pidx][1];
  assign w_lk_target = w_lk_taken ? w_lk_btb_tgt : pred_pc + C_INC;

  assign w_up_pidx      = upd_pc[HIST_W-1:0] ^ r_ghr;
  assign w_up_fall      = upd_pc + C_INC;
  assign w_up_taken     = w_up_valid && (w_up_tag == upd_pc[PC_W-1:IDX_W]) && r_pht[w_up_pidx][1];
  assign w_up_target    = w_up_taken ? w_up_btb_tgt : w_up_fall;
  assign w_actual_taken = (upd_next_pc != w_up_fall);
  assign w_correct      = (w_up_target == upd_next_pc);

  generate
    if (HIST_W == 1) begin : g_ghr_one
      assign w_ghr_next = w_actual_taken;
    end else begin : g_ghr_shift
      assign w_ghr_next = {r_ghr[HIST_W-2:0], w_actual_taken};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_out_valid <= 1'b0;
      pred_taken     <= 1'b0;
      pred_target    <= '0;
    end else begin
      pred_out_valid <= pred_valid;
      if (pred_valid) begin
        pred_taken  <= w_lk_taken;
        pred_target <= w_lk_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr       <= '0;
      correct_cnt <= '0;
      total_cnt   <= '0;
      for (int i = 0; i < PHT_N; i++) r_pht[i] <= SNT;
    end else if (upd_valid) begin
      r_ghr            <= w_ghr_next;
      r_pht[w_up_pidx] <= w_actual_taken ? sat_inc(r_pht[w_up_pidx]) : sat_dec(r_pht[w_up_pidx]);
      if (total_cnt != {CNT_W{1'b1}}) total_cnt <= total_cnt + CNT_W'(1);
      if (w_correct && (correct_cnt != {CNT_W{1'b1}})) correct_cnt <= correct_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gshare_btb_predictor.sv
// ---------------------------------------------------------------------------
// tb_gshare_btb_predictor: directed + random stimulus against an array model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gshare_btb_predictor;

  logic       clk = 1'b0;
  logic       rst;
  logic       pred_valid;
  logic [4:0] pred_pc;
  logic       upd_valid;
  logic [4:0] upd_pc, upd_next_pc;

  logic       ov_a, tk_a, ov_b, tk_b;
  logic [4:0] tgt_a, tgt_b;
  logic [7:0] cc_a, tc_a;
  logic [3:0] cc_b, tc_b;

  gshare_btb_predictor u_dut (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_out_valid(ov_a), .pred_taken(tk_a), .pred_target(tgt_a),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_next_pc(upd_next_pc),
    .correct_cnt(cc_a), .total_cnt(tc_a)
  );

  gshare_btb_predictor #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_out_valid(ov_b), .pred_taken(tk_b), .pred_target(tgt_b),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_next_pc(upd_next_pc),
    .correct_cnt(cc_b), .total_cnt(tc_b)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state, kept as plain integers
  int m_bv [4];
  int m_bt [4];
  int m_bg [4];
  int m_pht [4];
  int m_ghr;
  int m_corr, m_tot;
  int e_ov, e_tk, e_tgt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_bv[i] = 0; m_bt[i] = 0; m_bg[i] = 0; m_pht[i] = 0;
    end
    m_ghr = 0; m_corr = 0; m_tot = 0;
    e_ov = 0; e_tk = 0; e_tgt = 0;
  endtask

  task automatic model_predict(input int pc, output int tk, output int tgt);
    int bi, tag, pi;
    bi  = pc % 4;
    tag = pc / 4;
    pi  = (pc % 4) ^ m_ghr;
    tk  = (m_bv[bi] == 1 && m_bt[bi] == tag && m_pht[pi] >= 2) ? 1 : 0;
    tgt = (tk == 1) ? m_bg[pi == pi ? bi : bi] : (pc + 4) % 32;
  endtask

  task automatic model_update(input int pc, input int nxt);
    int tk, tgt, act, pi;
    act = (nxt != (pc + 4) % 32) ? 1 : 0;
    model_predict(pc, tk, tgt);
    m_tot++;
    if (tgt == nxt) m_corr++;
    pi = (pc % 4) ^ m_ghr;
    if (act == 1) begin
      if (m_pht[pi] < 3) m_pht[pi]++;
      m_bv[pc % 4] = 1; m_bt[pc % 4] = pc / 4; m_bg[pc % 4] = nxt;
    end else if (m_pht[pi] > 0) begin
      m_pht[pi]--;
    end
    m_ghr = (m_ghr * 2 + act) % 4;
  endtask

  task automatic cycle(input bit r, input bit pv, input int ppc,
                       input bit uv, input int upc, input int unx);
    int tk, tgt;
    rst = r; pred_valid = pv; pred_pc = 5'(ppc);
    upd_valid = uv; upd_pc = 5'(upc); upd_next_pc = 5'(unx);
    if (r) begin
      model_reset();
    end else begin
      e_ov = pv ? 1 : 0;
      if (pv) begin
        model_predict(ppc, tk, tgt);
        e_tk = tk; e_tgt = tgt;
      end
      if (uv) model_update(upc, unx);
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(ov_a), 32'(e_ov));
    check("taken",     32'(tk_a), 32'(e_tk));
    check("target",    32'(tgt_a), 32'(e_tgt));
    check("correct8",  32'(cc_a), 32'((m_corr > 255) ? 255 : m_corr));
    check("total8",    32'(tc_a), 32'((m_tot > 255) ? 255 : m_tot));
    check("correct4",  32'(cc_b), 32'((m_corr > 15) ? 15 : m_corr));
    check("total4",    32'(tc_b), 32'((m_tot > 15) ? 15 : m_tot));
    check("taken4",    32'(tk_b), 32'(e_tk));
    rst = 1'b0; pred_valid = 1'b0; upd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pred_valid = 1'b0; pred_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_next_pc = '0;
    model_reset();

    cycle(1, 1, 9, 1, 9, 1);
    cycle(0, 1, 9, 0, 0, 0);
    check("lk09_tgt_fixed", 32'(tgt_a), 32'h0D);
    cycle(0, 0, 0, 0, 0, 0);
    check("idle_ov_fixed", 32'(ov_a), 32'h0);

    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 9, 1);
    cycle(0, 1, 9, 0, 0, 0);
    check("trained_tk_fixed", 32'(tk_a), 32'h1);
    check("trained_tgt_fixed", 32'(tgt_a), 32'h01);
    cycle(0, 0, 0, 1, 9, 1);
    check("corr_after5_fixed", 32'(cc_a), 32'd1);
    check("tot_after5_fixed", 32'(tc_a), 32'd5);

    // same-cycle lookup and first taken update see pre-update state
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 9, 1, 9, 1);
    check("simul_tgt_fixed", 32'(tgt_a), 32'h0D);
    cycle(0, 1, 9, 0, 0, 0);
    check("next_tk_fixed", 32'(tk_a), 32'h0);

    cycle(0, 1, 30, 0, 0, 0);
    check("wrap_tgt_fixed", 32'(tgt_a), 32'h02);
    cycle(0, 0, 0, 1, 30, 2);

    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, (i * 7) % 32, ((i * 7) + 4) % 32);
    check("sat4_total_fixed", 32'(tc_b), 32'd15);
    for (int i = 0; i < 8; i++) cycle(0, 1, 5, 1, 5, 17);

    cycle(1, 1, 5, 1, 5, 17);
    check("rst_ov_fixed", 32'(ov_a), 32'h0);
    cycle(0, 1, 5, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      int upc, unx;
      upc = int'($urandom_range(0, 31));
      unx = ($urandom_range(0, 1) == 0) ? (upc + 4) % 32 : int'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) unx = (upc + 12) % 32;
      cycle($urandom_range(0, 79) == 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
            $urandom_range(0, 3) != 0, upc, unx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/gshare_btb_predictor.md
# gshare_btb_predictor

Parametrised two-level branch predictor for the fetch stage: a global history register (GHR) XOR-hashed with the PC indexes a pattern history table (PHT) of 2-bit saturating counters, and a direct-mapped, tagged branch target buffer (BTB) supplies taken targets. Fetch queries it through a registered lookup port. Branch resolution trains it through a separate update port. It also keeps saturating prediction-accuracy statistics.

## Interface
- PC_W, 5: PC / address width
- IDX_W, 2: BTB index bits; 2^IDX_W entries; tag width = PC_W-IDX_W
- HIST_W, 2: GHR length; PHT has 2^HIST_W entries; HIST_W <= PC_W
- PC_INC, 4: fall-through increment
- CNT_W, 8: statistics counter width

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  reset; synchronous, active-high
- pred_valid  in  1  lookup request
- pred_pc  in  PC_W  PC to predict
- pred_out_valid  out  1  registered lookup result valid
- pred_taken  out  1  predicted direction
- pred_target  out  PC_W  predicted next PC
- upd_valid  in  1  resolved branch present
- upd_pc  in  PC_W  resolved branch PC
- upd_next_pc  in  PC_W  actual next PC (effective address)
- correct_cnt  out  CNT_W  correct predictions at update
- total_cnt  out  CNT_W  total updates

## Operation
- Index/tag: btb_idx = pc[IDX_W-1:0], tag = pc[PC_W-1:IDX_W], pht_idx = pc[HIST_W-1:0] ^ GHR.
- Prediction function P(pc): hit = btb_valid[btb_idx] && btb_tag[btb_idx]==tag. Taken = hit && pht[pht_idx][1]. Target = btb_target[btb_idx] if taken, else (pc + PC_INC) mod 2^PC_W.
- Lookup: when pred_valid, P(pred_pc) is registered to pred_taken/pred_target and pred_out_valid=1. When pred_valid=0, pred_out_valid=0 and the data outputs hold their value.
- Update (upd_valid=1):
  - actual_taken = (upd_next_pc != upd_pc + PC_INC mod 2^PC_W).
  - Evaluate P(upd_pc) on pre-update state. correct = (target == upd_next_pc).
  - total_cnt++, and correct_cnt++ if correct. Both saturate at 2^CNT_W-1.
  - PHT[pht_idx] uses states SNT=0, WNT=1, WT=2, ST=3. Increments on taken, decrements on not-taken, saturating at ST and SNT.
  - BTB: on actual_taken, write valid=1, tag, target=upd_next_pc (this allocates on a miss and refreshes on a hit). On not-taken, the BTB is unchanged.
  - GHR = {GHR[HIST_W-2:0], actual_taken}. For HIST_W=1, GHR = actual_taken.
- Simultaneous lookup and update: the lookup uses pre-edge state; the update is not forwarded.
- PC arithmetic wraps modulo 2^PC_W.

## Timing
- Lookup latency: 1 cycle; a request at edge N produces its result after edge N. Throughput is 1 lookup and 1 update per cycle.
- The update is visible to lookups sampled on the following edge.
- Reset values: pred_out_valid=0, pred_taken=0, pred_target=0, correct_cnt=0, total_cnt=0, GHR=0, every PHT entry = SNT, every BTB valid = 0 (tags and targets = 0).
- rst dominates: with rst=1, pred_valid and upd_valid are ignored that cycle. Reset in the middle of a stream discards the pending lookup result.

## Structure
- Shared package bp_pkg: SNT/WNT/WT/ST constants, a 2-bit counter typedef, and the sat_inc/sat_dec functions (reused by later predictor variants).
- Sub-module btb_array holds the valid/tag/target storage. It has one combinational read port per requester (lookup, update) and one synchronous write port, and is parametrised by PC_W and IDX_W.
- The top level contains the PHT, GHR, hashing, output register, and statistics counters.

## Test plan
All scenarios use defaults except where noted.
- Reset, then lookup 0x09 → next cycle pred_out_valid=1, pred_taken=0, pred_target=0x0D. With no request the following cycle, pred_out_valid=0.
- Update 0x09→0x01 four times consecutively → BTB[1] = {valid, tag 0x2, target 0x01}, GHR=2'b11, PHT[2]=WT. Lookup 0x09 → taken, 0x01. A fifth identical update gives correct_cnt=1, total_cnt=5.
- In the same cycle, a lookup of 0x09 and its first taken update from reset → the lookup returns not-taken 0x0D. A lookup on the next cycle sees the BTB entry but PHT=SNT, so it is still not-taken.
- Lookup 0x1E → not-taken, target 0x02 (wrap). Update 0x1E→0x02 → counted correct, BTB unchanged, GHR shifts in 0.
- CNT_W=4, 20 not-taken updates → total_cnt=15 and correct_cnt=15, both saturated. Repeated taken updates leave the PHT entry at ST with no wrap.
- Assert rst together with upd_valid and pred_valid mid-stream → no training occurs, all state returns to reset values, and pred_out_valid=0 on the next cycle.
